// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: forwarding and load-use hazard controller.
// It tracks the destination registers of the three older in-flight
// instructions (EX, MEM, WB) and produces the 2-bit operand mux selects,
// a load-use stall, and a saturating stall-cycle counter for debug.
module fwd_sel_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] w_rs_5,
    input  logic [REG_W-1:0] w_rt_5,
    input  logic             w_rs_used,
    input  logic             w_rt_used,
    input  logic             w_issue_valid,
    input  logic             w_issue_wr_en,
    input  logic [REG_W-1:0] w_issue_rd_5,
    input  logic             w_issue_load,
    input  logic             w_flush,
    output logic [1:0]       w_fwd_a_2,
    output logic [1:0]       w_fwd_b_2,
    output logic             w_stall,
    output logic [CNT_W-1:0] w_stall_count_x
);

    // Mux select encodings.
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b11;

    // Pipeline slot state.
    logic             ex_valid,  mem_valid,  wb_valid;
    logic             ex_wr_en,  mem_wr_en,  wb_wr_en;
    logic [REG_W-1:0] ex_rd,     mem_rd,     wb_rd;
    logic             ex_load,   mem_load,   wb_load;

    logic [CNT_W-1:0] stall_count;

    // Per-slot, per-operand match terms.
    logic ex_hit_a, mem_hit_a, wb_hit_a;
    logic ex_hit_b, mem_hit_b, wb_hit_b;
    logic load_use;
    logic ex_take;

    // A slot can forward only if it holds a live register write to a
    // nonzero destination that equals the requested source index.
    function automatic logic slot_match(
        input logic             valid,
        input logic             wr_en,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] src
    );
        return valid & wr_en & (rd == src) & (src != '0);
    endfunction

    // Youngest producer wins: EX beats MEM beats WB, register file last.
    function automatic logic [1:0] pick_sel(
        input logic used,
        input logic hit_ex,
        input logic hit_mem,
        input logic hit_wb
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (used) begin
            if (hit_ex)
                sel = SEL_EX;
            else if (hit_mem)
                sel = SEL_MEM;
            else if (hit_wb)
                sel = SEL_WB;
        end
        return sel;
    endfunction

    // Match terms against the current slot contents.
    always_comb begin
        ex_hit_a  = slot_match(ex_valid,  ex_wr_en,  ex_rd,  w_rs_5);
        mem_hit_a = slot_match(mem_valid, mem_wr_en, mem_rd, w_rs_5);
        wb_hit_a  = slot_match(wb_valid,  wb_wr_en,  wb_rd,  w_rs_5);
        ex_hit_b  = slot_match(ex_valid,  ex_wr_en,  ex_rd,  w_rt_5);
        mem_hit_b = slot_match(mem_valid, mem_wr_en, mem_rd, w_rt_5);
        wb_hit_b  = slot_match(wb_valid,  wb_wr_en,  wb_rd,  w_rt_5);
    end

    // Load-use hazard: a load in EX cannot supply its data in time, so the
    // dependent decode instruction is held; a flush kills the consumer and
    // therefore suppresses the stall.
    always_comb begin
        load_use = w_issue_valid & ~w_flush & ex_valid & ex_load & ex_wr_en &
                   ((w_rs_used & ex_hit_a) | (w_rt_used & ex_hit_b));
        ex_take  = w_issue_valid & ~w_flush & ~load_use;
    end

    // Operand selects, forced to the register file while stalling.
    always_comb begin
        w_fwd_a_2 = SEL_RF;
        w_fwd_b_2 = SEL_RF;
        if (!load_use) begin
            w_fwd_a_2 = pick_sel(w_rs_used, ex_hit_a, mem_hit_a, wb_hit_a);
            w_fwd_b_2 = pick_sel(w_rt_used, ex_hit_b, mem_hit_b, wb_hit_b);
        end
    end

    assign w_stall         = load_use;
    assign w_stall_count_x = stall_count;

    // Slot shift pipeline: always advances, EX takes a bubble unless a
    // live, unflushed, unstalled instruction is issuing.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_wr_en  <= 1'b0;
            ex_rd     <= '0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_rd    <= '0;
            mem_load  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_wr_en  <= 1'b0;
            wb_rd     <= '0;
            wb_load   <= 1'b0;
        end else begin
            wb_valid  <= mem_valid;
            wb_wr_en  <= mem_wr_en;
            wb_rd     <= mem_rd;
            wb_load   <= mem_load;
            mem_valid <= ex_valid;
            mem_wr_en <= ex_wr_en;
            mem_rd    <= ex_rd;
            mem_load  <= ex_load;
            if (ex_take) begin
                ex_valid <= 1'b1;
                ex_wr_en <= w_issue_wr_en;
                ex_rd    <= w_issue_rd_5;
                ex_load  <= w_issue_load;
            end else begin
                ex_valid <= 1'b0;
                ex_wr_en <= 1'b0;
                ex_rd    <= '0;
                ex_load  <= 1'b0;
            end
        end
    end

    // Stall-cycle counter that sticks at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset)
            stall_count <= '0;
        else if (load_use && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end

endmodule
